// File: rtl/acc_pkg.sv
// Shared definitions for the Euler-step accumulator: FSM state encoding and the
// sign-extension helper used to widen products to the accumulator width.
package acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// Widens a two's-complement value to width w; a size cast of a signed operand replicates the sign bit.
`ifndef ACC_SEXT
`define ACC_SEXT(w, v) ((w)'($signed(v)))
`endif

// File: rtl/sat_add.sv
// W-bit two's-complement adder with signed-overflow flag.
// ACC_SATURATE_EN defined: clamp to signed max/min on overflow; otherwise wrap.
module sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W-1:0] raw;

    assign raw = a + b;
    // Only like-signed operands can overflow; the result then flips sign.
    assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef ACC_SATURATE_EN
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    always_comb begin
        sum = raw;
        if (ovf) begin
            sum = a[W-1] ? SMIN : SMAX;
        end
    end
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/euler_accumulator.sv
// Euler-step accumulator: sums Terms signed products onto a preloaded y_n and pulses done_acc.
// Saturating arithmetic is selected by defining ACC_SATURATE_EN (see sat_add).
//
//  state | meaning
//  IDLE  | waiting for start; start preloads sum with init
//  ACCUM | accepting one term per rising edge of done_mul_in
//  DONE  | result valid, done_acc high for this single cycle
module euler_accumulator
    import acc_pkg::*;
#(
    parameter int Size    = 8,
    parameter int AccSize = 16,
    parameter int Terms   = 4,
    parameter int CntW    = 3
) (
    input  logic               clk,
    input  logic               rst_async,
    input  logic               rst_sync,
    input  logic               start,
    input  logic [AccSize-1:0] init,
    input  logic               done_mul_in,
    input  logic [Size-1:0]    d,
    output logic               busy,
    output logic               done_acc,
    output logic [AccSize-1:0] sum,
    output logic               overflow
);

    localparam logic [CntW-1:0] LAST_TERM = CntW'(Terms - 1);

    acc_state_t         state;
    logic [CntW-1:0]    count;
    logic               prev_done;
    logic               acc_en;
    logic [AccSize-1:0] d_ext;
    logic [AccSize-1:0] add_sum;
    logic               add_ovf;

    assign d_ext  = `ACC_SEXT(AccSize, d);
    // A held product-valid level contributes exactly one term.
    assign acc_en = (state == ACCUM) && done_mul_in && !prev_done;

    assign busy     = (state == ACCUM);
    assign done_acc = (state == DONE);

    sat_add #(
        .W(AccSize)
    ) u_sat_add (
        .a  (sum),
        .b  (d_ext),
        .sum(add_sum),
        .ovf(add_ovf)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            prev_done <= 1'b0;
            overflow  <= 1'b0;
        end else if (!rst_sync) begin
            state     <= IDLE;
            sum       <= '0;
            count     <= '0;
            prev_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            prev_done <= done_mul_in;
            case (state)
                IDLE: begin
                    if (start) begin
                        sum      <= init;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (acc_en) begin
                        sum      <= add_sum;
                        count    <= count + 1'b1;
                        overflow <= overflow | add_ovf;
                        if (count == LAST_TERM) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_euler_accumulator.sv
// Self-checking bench for euler_accumulator (Size=8, AccSize=16, Terms=4).
// Expected results are queued when a sum is launched and compared on each done_acc pulse.
module tb_euler_accumulator;

    logic        clk;
    logic        rst_async;
    logic        rst_sync;
    logic        start;
    logic [15:0] init;
    logic        done_mul_in;
    logic [7:0]  d;
    logic        busy;
    logic        done_acc;
    logic [15:0] sum;
    logic        overflow;

    typedef struct {
        logic [15:0] sum;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   err_cnt    = 0;
    int   chk_cnt    = 0;
    int   done_seen  = 0;
    int   done_want  = 0;
    bit   width_pend = 0;

    euler_accumulator #(
        .Size(8), .AccSize(16), .Terms(4), .CntW(3)
    ) dut (
        .clk        (clk),
        .rst_async  (rst_async),
        .rst_sync   (rst_sync),
        .start      (start),
        .init       (init),
        .done_mul_in(done_mul_in),
        .d          (d),
        .busy       (busy),
        .done_acc   (done_acc),
        .sum        (sum),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one pop per done_acc pulse, and the pulse must be one cycle wide.
    always @(posedge clk) begin
        #1;
        if (width_pend) begin
            width_pend = 0;
            check("done_pulse_width", {31'b0, done_acc}, 32'd0);
        end
        if (done_acc) begin
            done_seen++;
            width_pend = 1;
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done_acc}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", {16'b0, sum}, {16'b0, e.sum});
                check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
            end
        end
    end

    task automatic push_exp(input logic [15:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        sb.push_back(e);
        done_want++;
    endtask

    task automatic do_start(input logic [15:0] v);
        @(negedge clk);
        start = 1'b1;
        init  = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic strobe(input logic [7:0] v);
        @(negedge clk);
        done_mul_in = 1'b1;
        d           = v;
        @(negedge clk);
        done_mul_in = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_seen < done_want && k < 20) begin
            @(posedge clk);
            k++;
        end
        #2;
        check("done_count", done_seen, done_want);
    endtask

    initial begin
        rst_async   = 1'b1;
        rst_sync    = 1'b1;
        start       = 1'b0;
        init        = '0;
        done_mul_in = 1'b0;
        d           = '0;
        #12;
        check("rst_sum", {16'b0, sum}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done_acc}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst_async = 1'b0;

        // 1: basic sum, and result appears the cycle after the last accepted term
        push_exp(16'h001D, 1'b0);
        do_start(16'h0010);
        check("busy_accum", {31'b0, busy}, 32'd1);
        strobe(8'd3);
        strobe(8'd5);
        strobe(8'hFE);
        strobe(8'd7);
        check("latency", {31'b0, done_acc}, 32'd1);
        wait_done();
        check("idle_after_done", {31'b0, busy}, 32'd0);

        // 2: held level counts once
        push_exp(16'h0007, 1'b0);
        do_start(16'h0000);
        @(negedge clk);
        done_mul_in = 1'b1;
        d           = 8'd4;
        repeat (3) @(negedge clk);
        done_mul_in = 1'b0;
        strobe(8'd1);
        strobe(8'd1);
        strobe(8'd1);
        wait_done();

        // 3: signed overflow
`ifdef ACC_SATURATE_EN
        push_exp(16'h7FFF, 1'b1);
`else
        push_exp(16'h81EC, 1'b1);
`endif
        do_start(16'h7FF0);
        repeat (4) strobe(8'd127);
        wait_done();

        // 4a: asynchronous abort mid-sum
        do_start(16'h0100);
        strobe(8'd2);
        strobe(8'd2);
        #2;
        rst_async = 1'b1;
        #1;
        check("arst_sum", {16'b0, sum}, 32'd0);
        check("arst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_async = 1'b0;
        strobe(8'd2);
        strobe(8'd2);
        repeat (3) @(negedge clk);
        check("arst_no_done", done_seen, done_want);
        check("arst_idle", {31'b0, busy}, 32'd0);

        // 4b: synchronous clear takes effect at the next posedge
        do_start(16'h0100);
        strobe(8'd2);
        strobe(8'd2);
        rst_sync = 1'b0;
        #1;
        check("srst_before_edge", {16'b0, sum}, 32'h0104);
        @(posedge clk);
        #1;
        check("srst_sum", {16'b0, sum}, 32'd0);
        check("srst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_sync = 1'b1;
        strobe(8'd2);
        strobe(8'd2);
        repeat (3) @(negedge clk);
        check("srst_no_done", done_seen, done_want);

        // 5: start ignored while accumulating
        push_exp(16'h0055, 1'b0);
        do_start(16'h0050);
        strobe(8'd2);
        do_start(16'h1234);
        check("start_ign_busy", {31'b0, busy}, 32'd1);
        check("start_ign_sum", {16'b0, sum}, 32'h0052);
        strobe(8'd1);
        strobe(8'd1);
        strobe(8'd1);
        wait_done();

        // 6: done edge coincident with start is dropped
        push_exp(16'h0024, 1'b0);
        @(negedge clk);
        start       = 1'b1;
        init        = 16'h0020;
        done_mul_in = 1'b1;
        d           = 8'd9;
        @(negedge clk);
        start       = 1'b0;
        done_mul_in = 1'b0;
        check("collide_sum", {16'b0, sum}, 32'h0020);
        strobe(8'd1);
        strobe(8'd1);
        strobe(8'd1);
        check("collide_busy", {31'b0, busy}, 32'd1);
        strobe(8'd1);
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
